// File: rtl/gerenciador_chamadas_pkg.sv
`default_nettype none
// ============================================================================
// Package : pacote_elevador
// Shared floor count, FSM state encoding and direction codes for the scheduler.
// Revision: 1.0 - initial release
// ============================================================================
package pacote_elevador;

  localparam int NUM_ANDARES = 4;
  localparam int ANDAR_W     = 2;

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    ESCOLHER  = 2'd1,
    SOLICITAR = 2'd2,
    AGUARDAR  = 2'd3
  } estado_t;

  localparam logic [1:0] SUBINDO  = 2'b10;
  localparam logic [1:0] DESCENDO = 2'b01;
  localparam logic [1:0] PARADO   = 2'b00;

endpackage
`default_nettype wire

// File: rtl/gerenciador_chamadas_seletor.sv
`default_nettype none
// ============================================================================
// Module  : seletor_proximo_andar
// SCAN selection: nearest pending floor ahead of the sweep, else nearest behind.
// Revision: 1.0 - initial release
// ============================================================================
module seletor_proximo_andar #(
  parameter int NUM_ANDARES = pacote_elevador::NUM_ANDARES,
  parameter int ANDAR_W     = pacote_elevador::ANDAR_W
) (
  input  logic [NUM_ANDARES-1:0] i_pendentes,
  input  logic [ANDAR_W-1:0]     i_andar_atual,
  input  logic [1:0]             i_sweep,
  output logic                   o_encontrado,
  output logic [ANDAR_W-1:0]     o_andar_escolhido,
  output logic                   o_inverter_sweep
);
  import pacote_elevador::*;

  logic               w_acima_ok;
  logic [ANDAR_W-1:0] w_acima;
  logic               w_abaixo_ok;
  logic [ANDAR_W-1:0] w_abaixo;
  logic               w_aqui;
  logic               w_frente_ok;
  logic [ANDAR_W-1:0] w_frente;
  logic               w_tras_ok;
  logic [ANDAR_W-1:0] w_tras;

  always_comb begin
    w_acima_ok  = 1'b0;
    w_acima     = '0;
    w_abaixo_ok = 1'b0;
    w_abaixo    = '0;
    w_aqui      = 1'b0;
    // Descending scan leaves the closest floor above in w_acima, ascending the closest below.
    for (int i = NUM_ANDARES - 1; i >= 0; i--) begin
      if (i > int'(i_andar_atual) && i_pendentes[i]) begin
        w_acima_ok = 1'b1;
        w_acima    = ANDAR_W'(i);
      end
    end
    for (int i = 0; i < NUM_ANDARES; i++) begin
      if (i < int'(i_andar_atual) && i_pendentes[i]) begin
        w_abaixo_ok = 1'b1;
        w_abaixo    = ANDAR_W'(i);
      end
      if (i == int'(i_andar_atual) && i_pendentes[i]) begin
        w_aqui = 1'b1;
      end
    end
  end

  always_comb begin
    w_frente_ok = (i_sweep == SUBINDO) ? w_acima_ok  : w_abaixo_ok;
    w_frente    = (i_sweep == SUBINDO) ? w_acima     : w_abaixo;
    w_tras_ok   = (i_sweep == SUBINDO) ? w_abaixo_ok : w_acima_ok;
    w_tras      = (i_sweep == SUBINDO) ? w_abaixo    : w_acima;

    o_encontrado      = 1'b1;
    o_andar_escolhido = '0;
    o_inverter_sweep  = 1'b0;
    if (w_frente_ok) begin
      o_andar_escolhido = w_frente;
    end else if (w_tras_ok) begin
      o_andar_escolhido = w_tras;
      o_inverter_sweep  = 1'b1;
    end else if (w_aqui) begin
      o_andar_escolhido = i_andar_atual;
    end else begin
      o_encontrado = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/gerenciador_chamadas.sv
`default_nettype none
// ============================================================================
// Module  : gerenciador_chamadas
// Latches floor calls, picks the next destination by SCAN and hands it off.
// Revision: 1.0 - initial release
// ============================================================================
module gerenciador_chamadas #(
  parameter int NUM_ANDARES = pacote_elevador::NUM_ANDARES,
  parameter int ANDAR_W     = pacote_elevador::ANDAR_W
) (
  input  logic                   clock_in,
  input  logic                   reset_n,
  input  logic [NUM_ANDARES-1:0] chamada_pulso,
  input  logic [ANDAR_W-1:0]     andar_atual,
  input  logic                   req_aceito,
  input  logic                   chegou,
  output logic [ANDAR_W-1:0]     destino,
  output logic                   req_valido,
  output logic [NUM_ANDARES-1:0] chamadas_pendentes,
  output logic [1:0]             direcao,
  output logic                   ocupado
);
  import pacote_elevador::*;

  estado_t                r_estado;
  estado_t                w_estado_prox;
  logic [NUM_ANDARES-1:0] r_pendentes;
  logic [ANDAR_W-1:0]     r_destino;
  logic [ANDAR_W-1:0]     w_destino_prox;
  logic [1:0]             r_sweep;
  logic [1:0]             w_sweep_prox;
  logic [1:0]             r_direcao;
  logic [1:0]             w_direcao_prox;
  logic [ANDAR_W-1:0]     w_andar;
  logic [NUM_ANDARES-1:0] w_set;
  logic [NUM_ANDARES-1:0] w_clear;
  logic                   w_encontrado;
  logic [ANDAR_W-1:0]     w_escolhido;
  logic                   w_inverter;

  function automatic logic [NUM_ANDARES-1:0] f_onehot(input logic [ANDAR_W-1:0] a);
    logic [NUM_ANDARES-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_ANDARES; i++) begin
      if (i == int'(a)) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Out-of-range floor reports are folded onto floor 0.
  assign w_andar = (int'(andar_atual) >= NUM_ANDARES) ? '0 : andar_atual;

  assign w_set   = chamada_pulso & ~((r_estado == OCIOSO) ? f_onehot(w_andar) : '0);
  assign w_clear = (r_estado == AGUARDAR && chegou) ? f_onehot(r_destino) : '0;

  seletor_proximo_andar #(
    .NUM_ANDARES (NUM_ANDARES),
    .ANDAR_W     (ANDAR_W)
  ) u_seletor (
    .i_pendentes       (r_pendentes),
    .i_andar_atual     (w_andar),
    .i_sweep           (r_sweep),
    .o_encontrado      (w_encontrado),
    .o_andar_escolhido (w_escolhido),
    .o_inverter_sweep  (w_inverter)
  );

  always_comb begin
    w_estado_prox  = r_estado;
    w_destino_prox = r_destino;
    w_sweep_prox   = r_sweep;
    case (r_estado)
      OCIOSO: begin
        if (r_pendentes != '0) w_estado_prox = ESCOLHER;
      end
      ESCOLHER: begin
        if (w_encontrado) begin
          w_destino_prox = w_escolhido;
          w_estado_prox  = SOLICITAR;
          if (w_inverter) w_sweep_prox = (r_sweep == SUBINDO) ? DESCENDO : SUBINDO;
        end else begin
          w_estado_prox = OCIOSO;
        end
      end
      SOLICITAR: begin
        if (req_aceito) w_estado_prox = AGUARDAR;
      end
      AGUARDAR: begin
        if (chegou) w_estado_prox = ESCOLHER;
      end
      default: w_estado_prox = OCIOSO;
    endcase

    // Direction tracks the upcoming state so it lines up with req_valido.
    if (w_estado_prox == OCIOSO)        w_direcao_prox = PARADO;
    else if (w_destino_prox > w_andar)  w_direcao_prox = SUBINDO;
    else if (w_destino_prox < w_andar)  w_direcao_prox = DESCENDO;
    else                                w_direcao_prox = PARADO;
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_estado    <= OCIOSO;
      r_pendentes <= '0;
      r_destino   <= '0;
      r_sweep     <= SUBINDO;
      r_direcao   <= PARADO;
    end else begin
      r_estado    <= w_estado_prox;
      r_pendentes <= (r_pendentes | w_set) & ~w_clear;
      r_destino   <= w_destino_prox;
      r_sweep     <= w_sweep_prox;
      r_direcao   <= w_direcao_prox;
    end
  end

  assign destino            = r_destino;
  assign req_valido         = (r_estado == SOLICITAR);
  assign chamadas_pendentes = r_pendentes;
  assign direcao            = r_direcao;
  assign ocupado            = (r_estado != OCIOSO);

endmodule
`default_nettype wire

// File: tb/tb_gerenciador_chamadas.sv
`default_nettype none
// ============================================================================
// Module  : tb_gerenciador_chamadas
// Directed stimulus with a request scoreboard for gerenciador_chamadas.
// Revision: 1.0 - initial release
// ============================================================================
module tb_gerenciador_chamadas;
  import pacote_elevador::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] chamada_pulso;
  logic [1:0] andar_atual;
  logic       req_aceito;
  logic       chegou;
  logic [1:0] destino;
  logic       req_valido;
  logic [3:0] chamadas_pendentes;
  logic [1:0] direcao;
  logic       ocupado;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [1:0] dest;
    logic [1:0] dir;
  } exp_t;
  exp_t q[$];
  exp_t cur;
  logic prev_req = 1'b0;

  always #5 clk = ~clk;

  gerenciador_chamadas #(.NUM_ANDARES(4), .ANDAR_W(2)) dut (
    .clock_in           (clk),
    .reset_n            (reset_n),
    .chamada_pulso      (chamada_pulso),
    .andar_atual        (andar_atual),
    .req_aceito         (req_aceito),
    .chegou             (chegou),
    .destino            (destino),
    .req_valido         (req_valido),
    .chamadas_pendentes (chamadas_pendentes),
    .direcao            (direcao),
    .ocupado            (ocupado)
  );

  task automatic check(input string nome, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nome, act, exp);
    end
  endtask

  // Monitor: every new request is matched against the next expected entry.
  always @(negedge clk) begin
    if (req_valido && !prev_req) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req: got destino=%0d, expected no request", destino);
      end else begin
        cur = q.pop_front();
        check("req_destino", int'(destino), int'(cur.dest));
        check("req_direcao", int'(direcao), int'(cur.dir));
      end
    end else if (req_valido) begin
      check("destino_stable", int'(destino), int'(cur.dest));
    end
    prev_req = req_valido;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] m);
    chamada_pulso = m;
    tick();
    chamada_pulso = 4'b0000;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!req_valido && n < 20) begin
      tick();
      n++;
    end
    check("req_timeout", int'(req_valido), 1);
  endtask

  task automatic serve(input logic [1:0] dest);
    req_aceito = 1'b1;
    tick();
    req_aceito = 1'b0;
    check("req_drop", int'(req_valido), 0);
    andar_atual = dest;
    chegou = 1'b1;
    tick();
    chegou = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with calls active
    reset_n = 1'b0;
    chamada_pulso = 4'b1111;
    andar_atual = 2'd0;
    req_aceito = 1'b0;
    chegou = 1'b0;
    repeat (3) tick();
    check("rst_pend", int'(chamadas_pendentes), 0);
    check("rst_req", int'(req_valido), 0);
    check("rst_destino", int'(destino), 0);
    check("rst_direcao", int'(direcao), 0);
    check("rst_ocupado", int'(ocupado), 0);
    chamada_pulso = 4'b0000;
    reset_n = 1'b1;
    repeat (3) tick();
    check("post_rst_pend", int'(chamadas_pendentes), 0);
    check("post_rst_ocupado", int'(ocupado), 0);

    // Single call with stalled accept
    andar_atual = 2'd0;
    q.push_back('{dest: 2'd2, dir: SUBINDO});
    pulse(4'b0100);
    check("single_pend", int'(chamadas_pendentes), 4'b0100);
    tick();
    tick();
    check("single_latency", int'(req_valido), 1);
    check("single_direcao", int'(direcao), int'(SUBINDO));
    repeat (5) tick();
    check("stall_destino", int'(destino), 2);
    check("stall_req", int'(req_valido), 1);
    serve(2'd2);
    check("single_clear", int'(chamadas_pendentes), 0);
    tick();
    tick();
    check("single_idle", int'(ocupado), 0);
    check("single_parado", int'(direcao), int'(PARADO));

    // SCAN ordering with reversal
    andar_atual = 2'd1;
    q.push_back('{dest: 2'd2, dir: SUBINDO});
    q.push_back('{dest: 2'd3, dir: SUBINDO});
    q.push_back('{dest: 2'd0, dir: DESCENDO});
    pulse(4'b1101);
    check("scan_pend", int'(chamadas_pendentes), 4'b1101);
    wait_req();
    serve(2'd2);
    check("scan_pend_a", int'(chamadas_pendentes), 4'b1001);
    wait_req();
    serve(2'd3);
    check("scan_pend_b", int'(chamadas_pendentes), 4'b0001);
    wait_req();
    serve(2'd0);
    check("scan_pend_c", int'(chamadas_pendentes), 0);
    tick();
    tick();
    check("scan_idle", int'(ocupado), 0);

    // Call for the current floor while idle
    andar_atual = 2'd1;
    pulse(4'b0010);
    check("same_floor_pend", int'(chamadas_pendentes), 0);
    repeat (4) tick();
    check("same_floor_pend2", int'(chamadas_pendentes), 0);
    check("same_floor_idle", int'(ocupado), 0);

    // Arrival clear beats a same-cycle call on that floor
    andar_atual = 2'd0;
    q.push_back('{dest: 2'd3, dir: SUBINDO});
    pulse(4'b1000);
    wait_req();
    req_aceito = 1'b1;
    tick();
    req_aceito = 1'b0;
    andar_atual = 2'd3;
    chegou = 1'b1;
    chamada_pulso = 4'b1000;
    tick();
    chegou = 1'b0;
    chamada_pulso = 4'b0000;
    check("clear_wins", int'(chamadas_pendentes), 0);
    tick();
    tick();
    check("clear_idle", int'(ocupado), 0);

    // Asynchronous reset during a pending request
    andar_atual = 2'd0;
    q.push_back('{dest: 2'd2, dir: SUBINDO});
    pulse(4'b0100);
    wait_req();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_req", int'(req_valido), 0);
    check("arst_pend", int'(chamadas_pendentes), 0);
    check("arst_ocupado", int'(ocupado), 0);
    check("arst_direcao", int'(direcao), 0);
    tick();
    reset_n = 1'b1;
    chegou = 1'b1;
    tick();
    chegou = 1'b0;
    tick();
    check("stray_chegou_ocupado", int'(ocupado), 0);
    check("stray_chegou_pend", int'(chamadas_pendentes), 0);
    check("stray_chegou_req", int'(req_valido), 0);

    repeat (2) tick();
    check("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
